// File: rtl/countdown_timer_if.sv
// Control/data bundle between the watch timer-mode controller and countdown_timer.
// No latency of its own; pure wiring.
// No backpressure: commands are single-cycle pulses sampled every clk.
interface countdown_timer_if;
  logic       tick;
  logic       load;
  logic       start;
  logic       stop;
  logic       clear;
  logic [2:0] set_min_t;
  logic [3:0] set_min_u;
  logic [2:0] set_sec_t;
  logic [3:0] set_sec_u;
  logic [2:0] min_t;
  logic [3:0] min_u;
  logic [2:0] sec_t;
  logic [3:0] sec_u;
  logic       running;
  logic       done;
  logic       alarm;

  // Controller side: issues commands and preset digits, observes the count.
  modport master (
    output tick, load, start, stop, clear,
    output set_min_t, set_min_u, set_sec_t, set_sec_u,
    input  min_t, min_u, sec_t, sec_u, running, done, alarm
  );

  // Timer side.
  modport slave (
    input  tick, load, start, stop, clear,
    input  set_min_t, set_min_u, set_sec_t, set_sec_u,
    output min_t, min_u, sec_t, sec_u, running, done, alarm
  );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with registered done pulse and tick-bounded alarm.
// Latency: every command/tick is visible on outputs one clk after it is sampled.
// No backpressure: commands are pulses acted on once per cycle high.
module countdown_timer #(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_t;

  localparam logic [7:0] ALARM_LIM = ALARM_TICKS[7:0];

  state_t     state_q, state_d;
  logic [2:0] min_t_q, min_t_d;
  logic [3:0] min_u_q, min_u_d;
  logic [2:0] sec_t_q, sec_t_d;
  logic [3:0] sec_u_q, sec_u_d;
  logic [7:0] acnt_q, acnt_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       alarm_q, alarm_d;

  logic [2:0] dec_min_t;
  logic [3:0] dec_min_u;
  logic [2:0] dec_sec_t;
  logic [3:0] dec_sec_u;
  logic       cnt_zero;
  logic       cnt_one;
  logic [7:0] acnt_inc;

  // One-second borrow chain: each digit wraps and borrows only when its lower neighbour did.
  always_comb begin
    dec_sec_u = (sec_u_q == 4'd0) ? 4'd9 : sec_u_q - 4'd1;
    dec_sec_t = sec_t_q;
    dec_min_u = min_u_q;
    dec_min_t = min_t_q;
    if (sec_u_q == 4'd0) begin
      dec_sec_t = (sec_t_q == 3'd0) ? 3'd5 : sec_t_q - 3'd1;
      if (sec_t_q == 3'd0) begin
        dec_min_u = (min_u_q == 4'd0) ? 4'd9 : min_u_q - 4'd1;
        if (min_u_q == 4'd0) begin
          dec_min_t = min_t_q - 3'd1;
        end
      end
    end
  end

  assign cnt_zero = (min_t_q == 3'd0) && (min_u_q == 4'd0) && (sec_t_q == 3'd0) && (sec_u_q == 4'd0);
  assign cnt_one  = (min_t_q == 3'd0) && (min_u_q == 4'd0) && (sec_t_q == 3'd0) && (sec_u_q == 4'd1);
  assign acnt_inc = acnt_q + 8'd1;

  // Next-state and next-output logic; clear overrides everything, then stop > start > load.
  always_comb begin
    state_d = state_q;
    min_t_d = min_t_q;
    min_u_d = min_u_q;
    sec_t_d = sec_t_q;
    sec_u_d = sec_u_q;
    acnt_d  = acnt_q;
    done_d  = 1'b0;

    if (bus.clear) begin
      state_d = S_IDLE;
      min_t_d = 3'd0;
      min_u_d = 4'd0;
      sec_t_d = 3'd0;
      sec_u_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.stop) begin
            state_d = S_IDLE;
          end else if (bus.start) begin
            if (!cnt_zero) state_d = S_RUN;
          end else if (bus.load) begin
            min_t_d = (bus.set_min_t > 3'd5) ? 3'd5 : bus.set_min_t;
            min_u_d = (bus.set_min_u > 4'd9) ? 4'd9 : bus.set_min_u;
            sec_t_d = (bus.set_sec_t > 3'd5) ? 3'd5 : bus.set_sec_t;
            sec_u_d = (bus.set_sec_u > 4'd9) ? 4'd9 : bus.set_sec_u;
          end
        end
        S_RUN: begin
          if (bus.tick) begin
            min_t_d = dec_min_t;
            min_u_d = dec_min_u;
            sec_t_d = dec_sec_t;
            sec_u_d = dec_sec_u;
          end
          // Reaching 00:00 always expires, even with a coincident stop: pausing at zero is meaningless.
          if (bus.tick && cnt_one) begin
            state_d = S_ALARM;
            done_d  = 1'b1;
            acnt_d  = 8'd0;
          end else if (bus.stop) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (!bus.stop && bus.start) state_d = S_RUN;
        end
        S_ALARM: begin
          if (bus.stop || bus.start) begin
            state_d = S_IDLE;
          end else if (bus.tick) begin
            acnt_d = acnt_inc;
            if (acnt_inc == ALARM_LIM) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    running_d = (state_d == S_RUN);
    alarm_d   = (state_d == S_ALARM);
  end

  // State, count and flag registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      min_t_q   <= 3'd0;
      min_u_q   <= 4'd0;
      sec_t_q   <= 3'd0;
      sec_u_q   <= 4'd0;
      acnt_q    <= 8'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_t_q   <= min_t_d;
      min_u_q   <= min_u_d;
      sec_t_q   <= sec_t_d;
      sec_u_q   <= sec_u_d;
      acnt_q    <= acnt_d;
      running_q <= running_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end

  assign bus.min_t   = min_t_q;
  assign bus.min_u   = min_u_q;
  assign bus.sec_t   = sec_t_q;
  assign bus.sec_u   = sec_u_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.alarm   = alarm_q;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Four-digit BCD countdown timer (MM:SS, 00:00–59:59) for the watch's timer mode. It consumes the 1 Hz tick from the timebase and decrements through a digit-level borrow chain, which is the down-counting counterpart of the watch's carry chain. It signals expiry with a one-cycle `done` pulse and a bounded `alarm` level for the buzzer and display blocks.

## Interface
- `ALARM_TICKS`, default 10: number of `tick` pulses `alarm` stays high after expiry (1–255).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `tick` in 1: 1 Hz enable, one `clk` wide.
- `load` in 1: capture the `set_*` digits (honoured in IDLE only).
- `start` in 1: pulse; run or resume.
- `stop` in 1: pulse; pause.
- `clear` in 1: pulse; abort to IDLE and zero the count.
- `set_min_t` in 3: minutes tens digit.
- `set_min_u` in 4: minutes units digit.
- `set_sec_t` in 3: seconds tens digit.
- `set_sec_u` in 4: seconds units digit.
- `min_t` out 3, `min_u` out 4, `sec_t` out 3, `sec_u` out 4: current count, registered.
- `running` out 1: high in RUN.
- `done` out 1: one-cycle expiry pulse.
- `alarm` out 1: high in ALARM.

## Operation
- States: IDLE, RUN, PAUSE, ALARM. All outputs are registered.
- Reset values: state IDLE, all digits 0, `running`=0, `done`=0, `alarm`=0, alarm tick counter 0.
- Command priority when pulses coincide: `clear` > `stop` > `start` > `load`.
- `clear` in any state: go to IDLE, zero all digits, drop `alarm`.
- IDLE:
  - `load` captures the `set_*` digits with clamping: units digit >9 becomes 9; tens digit >5 becomes 5.
  - `start` with a nonzero count goes to RUN.
  - `start` with count 00:00 is ignored.
  - `tick` is ignored.
- RUN:
  - Each `tick` decrements the count by one second.
  - `stop` goes to PAUSE. A `tick` in the same cycle as `stop` is still applied.
  - `load` is ignored.
- PAUSE:
  - The count is frozen and `tick` is ignored.
  - `start` goes to RUN.
  - `load` is ignored.
- Decrement borrow chain (the same `tick` propagates through all four digits in one cycle):
  - `sec_u`: 0 wraps to 9 and borrows from `sec_t`; otherwise decrements.
  - `sec_t`: 0 wraps to 5 and borrows from `min_u`.
  - `min_u`: 0 wraps to 9 and borrows from `min_t`.
  - `min_t`: decrements.
  - Example: 10:00 decrements to 09:59.
- Expiry: a `tick` in RUN at count 00:01 makes the count 00:00, enters ALARM, and pulses `done` for exactly one cycle. The count never underflows.
- ALARM:
  - `alarm` is high. The count holds at 00:00.
  - Each `tick` increments the alarm counter. At `ALARM_TICKS` ticks, go to IDLE and drop `alarm`.
  - `start` or `stop` acknowledges the alarm: go to IDLE immediately.
  - `load` is ignored.
  - The alarm counter clears on entry to ALARM.
- Reset asserted mid-run returns everything to the reset values immediately. This is asynchronous: no clock edge is needed.

## Timing
- Latency for `load`, `start`, `stop`, `clear` and `tick`: the effect is visible on the outputs after the same `clk` edge that samples the input, i.e. one cycle after assertion.
- `done` and `alarm` rise on the same edge that writes 00:00. `running` falls on that edge.
- `alarm` falls on the edge that samples the `ALARM_TICKS`-th `tick`, or the acknowledging pulse.
- Inputs are synchronous to `clk`. Multi-cycle pulses act once per cycle high.
- A held `start` in IDLE has no extra effect after RUN is entered.

## Test plan
- Reset, then `load` 00:03, then `start`, then 3 ticks: count 00:02, 00:01, 00:00. `done` high for one cycle on the third tick. `alarm`=1. `running`=0.
- `load` 10:00, `start`, 1 tick: count 09:59, `running`=1. Check the full borrow chain again at 01:00 → 00:59.
- `load` with set digits 7:C:6:F (`min_t`=7, `min_u`=12, `sec_t`=6, `sec_u`=15): clamps to 59:59. `start`, 1 tick: 59:58.
- In RUN at 00:30, assert `stop` and `tick` in the same cycle: count 00:29, state PAUSE. Further ticks: no change. `start`, then 1 tick: 00:28.
- Expire with `ALARM_TICKS`=3: `alarm` stays high for 3 ticks, then IDLE with `alarm`=0. Repeat and send `stop` after 1 tick: `alarm` drops on the next edge.
- Assert `rst` mid-run at 05:17: all digits 0 and all flags 0 without a clock edge. After reset, `start` with count 00:00: stays IDLE, `running`=0.
